// File: rtl/muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : muldiv_sequencer                                                |
// | Purpose  : Multi-cycle controller for the shared HI/LO multiply/divide     |
// |            unit. Loads the selected unit, steps it ITERATIONS times,       |
// |            commits HI/LO and signals done, or aborts a DIV by zero.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module muldiv_sequencer #(
  parameter int ITERATIONS = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clck,
  input  logic       reset,
  input  logic       start,
  input  logic       op_div,
  input  logic       DivZeroOP,
  output logic [1:0] MulCtrl,
  output logic [1:0] DivCtrl,
  output logic       DivMulCtrl,
  output logic       HILOCtrl,
  output logic       busy,
  output logic       done,
  output logic       div_zero_exc
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_DZERO = 3'd5
  } state_t;

  localparam logic [1:0]       c_hold = 2'b00;
  localparam logic [1:0]       c_load = 2'b01;
  localparam logic [1:0]       c_step = 2'b10;
  localparam logic [CNT_W-1:0] c_iter = CNT_W'(ITERATIONS);
  localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_op_nxt;

  // Next-state, counter and latched-op logic; start is only honoured in IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (start && op_div && DivZeroOP) begin
          w_state_nxt = S_DZERO;
        end else if (start) begin
          w_state_nxt = S_LOAD;
          w_op_nxt    = op_div;
        end
      end
      S_LOAD: begin
        w_cnt_nxt   = c_iter;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Leaving on count==1 yields exactly ITERATIONS step cycles
        w_cnt_nxt = r_cnt - c_one;
        if (r_cnt == c_one) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      S_DZERO: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register on the falling edge; outputs are registered copies of the
  // decode of the state being entered, so they always match r_state/r_op
  always_ff @(negedge clck) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_op         <= 1'b0;
      MulCtrl      <= c_hold;
      DivCtrl      <= c_hold;
      DivMulCtrl   <= 1'b0;
      HILOCtrl     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      div_zero_exc <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;

      MulCtrl <= c_hold;
      DivCtrl <= c_hold;
      if (w_state_nxt == S_LOAD) begin
        if (w_op_nxt) DivCtrl <= c_load;
        else          MulCtrl <= c_load;
      end else if (w_state_nxt == S_RUN) begin
        if (w_op_nxt) DivCtrl <= c_step;
        else          MulCtrl <= c_step;
      end

      DivMulCtrl   <= w_op_nxt;
      HILOCtrl     <= (w_state_nxt == S_WRITE);
      busy         <= (w_state_nxt != S_IDLE);
      done         <= (w_state_nxt == S_DONE);
      div_zero_exc <= (w_state_nxt == S_DZERO);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_muldiv_sequencer                                             |
// | Purpose  : Directed, table-driven bench for muldiv_sequencer (32 iters).   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_muldiv_sequencer;

  logic       clck;
  logic       reset;
  logic       start;
  logic       op_div;
  logic       DivZeroOP;
  logic [1:0] MulCtrl;
  logic [1:0] DivCtrl;
  logic       DivMulCtrl;
  logic       HILOCtrl;
  logic       busy;
  logic       done;
  logic       div_zero_exc;

  int n_checks = 0;
  int n_err    = 0;

  muldiv_sequencer #(.ITERATIONS(32), .CNT_W(6)) dut (
    .clck         (clck),
    .reset        (reset),
    .start        (start),
    .op_div       (op_div),
    .DivZeroOP    (DivZeroOP),
    .MulCtrl      (MulCtrl),
    .DivCtrl      (DivCtrl),
    .DivMulCtrl   (DivMulCtrl),
    .HILOCtrl     (HILOCtrl),
    .busy         (busy),
    .done         (done),
    .div_zero_exc (div_zero_exc)
  );

  // DUT updates on the falling edge; the bench samples and drives on the rising edge
  initial clck = 1'b1;
  always #5 clck = ~clck;

  // Per-operation summary measured over a fixed 40-cycle window after start
  typedef struct {
    int mld;        // cycles with MulCtrl = LOAD
    int mst;        // cycles with MulCtrl = STEP
    int dld;        // cycles with DivCtrl = LOAD
    int dst;        // cycles with DivCtrl = STEP
    int first_step; // first cycle with any STEP (0 = none)
    int hilo_cyc;   // first HILOCtrl cycle (0 = none)
    int hilo_n;
    int dmc;        // DivMulCtrl seen in the HILOCtrl cycle
    int done_cyc;
    int done_n;
    int exc_cyc;
    int exc_n;
    int busy_n;
    int viol;       // both Ctrl non-zero, or HILOCtrl with done
  } res_t;

  typedef struct {
    logic op;
    logic dz;
    int   inj;      // cycle at which a stray start(DIV, divisor 0) is pulsed
    res_t e;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input logic op, input logic dz, input int inj,
                              input int mld, input int mst, input int dld, input int dst,
                              input int fs, input int hc, input int hn, input int dmc,
                              input int dc, input int dn, input int ec, input int en,
                              input int bn);
    vec_t v;
    v.op = op; v.dz = dz; v.inj = inj;
    v.e.mld = mld; v.e.mst = mst; v.e.dld = dld; v.e.dst = dst;
    v.e.first_step = fs; v.e.hilo_cyc = hc; v.e.hilo_n = hn; v.e.dmc = dmc;
    v.e.done_cyc = dc; v.e.done_n = dn; v.e.exc_cyc = ec; v.e.exc_n = en;
    v.e.busy_n = bn; v.e.viol = 0;
    return v;
  endfunction

  // Issue start at the current rising edge and observe cycles 1..40
  task automatic run_op(input vec_t v, output res_t r);
    r = '{default: 0};
    start = 1'b1; op_div = v.op; DivZeroOP = v.dz;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clck);
      if (MulCtrl == 2'b01) r.mld++;
      if (DivCtrl == 2'b01) r.dld++;
      if (MulCtrl == 2'b10) r.mst++;
      if (DivCtrl == 2'b10) r.dst++;
      if ((MulCtrl == 2'b10 || DivCtrl == 2'b10) && r.first_step == 0) r.first_step = c;
      if (HILOCtrl) begin
        r.hilo_n++;
        if (r.hilo_cyc == 0) begin r.hilo_cyc = c; r.dmc = int'(DivMulCtrl); end
      end
      if (done) begin r.done_n++; if (r.done_cyc == 0) r.done_cyc = c; end
      if (div_zero_exc) begin r.exc_n++; if (r.exc_cyc == 0) r.exc_cyc = c; end
      if (busy) r.busy_n++;
      if ((MulCtrl != 2'b00 && DivCtrl != 2'b00) || (HILOCtrl && done)) r.viol++;
      start = 1'b0; op_div = 1'b0; DivZeroOP = 1'b0;
      if (c == v.inj) begin start = 1'b1; op_div = 1'b1; DivZeroOP = 1'b1; end
    end
  endtask

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    chk({tag, " mul_load"},   a.mld,        e.mld);
    chk({tag, " mul_step"},   a.mst,        e.mst);
    chk({tag, " div_load"},   a.dld,        e.dld);
    chk({tag, " div_step"},   a.dst,        e.dst);
    chk({tag, " first_step"}, a.first_step, e.first_step);
    chk({tag, " hilo_cyc"},   a.hilo_cyc,   e.hilo_cyc);
    chk({tag, " hilo_n"},     a.hilo_n,     e.hilo_n);
    chk({tag, " divmul"},     a.dmc,        e.dmc);
    chk({tag, " done_cyc"},   a.done_cyc,   e.done_cyc);
    chk({tag, " done_n"},     a.done_n,     e.done_n);
    chk({tag, " exc_cyc"},    a.exc_cyc,    e.exc_cyc);
    chk({tag, " exc_n"},      a.exc_n,      e.exc_n);
    chk({tag, " busy_n"},     a.busy_n,     e.busy_n);
    chk({tag, " protocol"},   a.viol,       e.viol);
  endtask

  initial begin
    res_t r;
    int   hn, dn, bn;

    //            op    dz   inj mld mst dld dst fs hilo hn dmc done dn exc en busy
    tbl[0] = mk(1'b0, 1'b0,  0,  1, 32,  0,  0, 2, 34,  1, 0,  35,  1, 0,  0, 35); // MULT
    tbl[1] = mk(1'b0, 1'b1,  0,  1, 32,  0,  0, 2, 34,  1, 0,  35,  1, 0,  0, 35); // MULT, zero flag ignored
    tbl[2] = mk(1'b1, 1'b0,  0,  0,  0,  1, 32, 2, 34,  1, 1,  35,  1, 0,  0, 35); // DIV
    tbl[3] = mk(1'b1, 1'b1,  0,  0,  0,  0,  0, 0,  0,  0, 0,   0,  0, 1,  1,  1); // DIV by zero
    tbl[4] = mk(1'b0, 1'b0, 10,  1, 32,  0,  0, 2, 34,  1, 0,  35,  1, 0,  0, 35); // stray start in RUN
    tbl[5] = mk(1'b1, 1'b0, 20,  0,  0,  1, 32, 2, 34,  1, 1,  35,  1, 0,  0, 35); // stray start in RUN
    tbl[6] = mk(1'b0, 1'b0, 34,  1, 32,  0,  0, 2, 34,  1, 0,  35,  1, 0,  0, 35); // stray start in WRITE
    tbl[7] = mk(1'b1, 1'b0, 35,  0,  0,  1, 32, 2, 34,  1, 1,  35,  1, 0,  0, 35); // stray start in DONE

    reset = 1'b1; start = 1'b0; op_div = 1'b0; DivZeroOP = 1'b0;
    repeat (3) @(posedge clck);
    reset = 1'b0;

    // Idle after reset: every output low
    for (int i = 0; i < 5; i++) begin
      @(posedge clck);
      chk($sformatf("reset_idle%0d", i),
          int'({MulCtrl, DivCtrl, DivMulCtrl, HILOCtrl, busy, done, div_zero_exc}), 0);
    end

    foreach (tbl[i]) begin
      run_op(tbl[i], r);
      cmp_res($sformatf("row%0d", i), r, tbl[i].e);
    end

    // Reset during RUN iteration 10 of a DIV (RUN occupies cycles 2..33)
    start = 1'b1; op_div = 1'b1; DivZeroOP = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clck);
      start = 1'b0; op_div = 1'b0;
    end
    chk("rst_pre_divstep", int'(DivCtrl), 2);
    chk("rst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clck);
    chk("rst_outputs", int'({MulCtrl, DivCtrl, DivMulCtrl, HILOCtrl, busy, done, div_zero_exc}), 0);
    reset = 1'b0;
    hn = 0; dn = 0; bn = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clck);
      if (HILOCtrl) hn++;
      if (done) dn++;
      if (busy) bn++;
    end
    chk("rst_no_hilo", hn, 0);
    chk("rst_no_done", dn, 0);
    chk("rst_no_busy", bn, 0);

    // Fresh operations after the abort complete normally
    run_op(tbl[2], r);
    cmp_res("post_rst_div", r, tbl[2].e);
    run_op(tbl[0], r);
    cmp_res("post_rst_mul", r, tbl[0].e);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
